// File: rtl/mem_instr_sequencer_if.sv
// Handshake and control bundle between the DataPath and its instruction sequencer.
// The master side (DataPath or bench) drives IR and handshakes; the slave side (sequencer) drives strobes.
interface mem_instr_sequencer_if;
    logic        run;
    logic        halt_req;
    logic [31:0] ir;
    logic        memFinished;
    logic        finished;
    logic [17:0] ctrl;
    logic [5:0]  opSelect;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;
    logic [3:0]  state;

    modport master (
        output run, halt_req, ir, memFinished, finished,
        input  ctrl, opSelect, busy, done, fault, fault_code, state
    );

    modport slave (
        input  run, halt_req, ir, memFinished, finished,
        output ctrl, opSelect, busy, done, fault, fault_code, state
    );
endinterface

// File: rtl/mem_instr_sequencer.sv
// Clocked T-state sequencer for instruction fetch plus ld/ldi/st execution.
// Every output is a registered Moore function of the state; wait states carry a timeout.
module mem_instr_sequencer #(
    parameter logic [4:0] OP_LD      = 5'b00000,
    parameter logic [4:0] OP_LDI     = 5'b00001,
    parameter logic [4:0] OP_ST      = 5'b00010,
    parameter logic [5:0] ALU_ADD_OP = 6'b000100,
    parameter int         TIMEOUT    = 16,
    parameter bit         CONTINUOUS = 1'b0
) (
    input logic                  Clock,
    input logic                  clear,
    mem_instr_sequencer_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    typedef logic [CW-1:0] cnt_t;

    // Strobe bit positions within ctrl, MSB first
    localparam int B_PCOUT   = 17;
    localparam int B_INCPC   = 16;
    localparam int B_MARIN   = 15;
    localparam int B_READ    = 14;
    localparam int B_WRITE   = 13;
    localparam int B_MDRIN   = 12;
    localparam int B_MDROUT  = 11;
    localparam int B_IRIN    = 10;
    localparam int B_GRA     = 9;
    localparam int B_GRB     = 8;
    localparam int B_ROUT    = 7;
    localparam int B_RIN     = 6;
    localparam int B_BAOUT   = 5;
    localparam int B_RYIN    = 4;
    localparam int B_IMMOUT  = 3;
    localparam int B_RZIN    = 2;
    localparam int B_RZLOOUT = 1;
    localparam int B_START   = 0;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_DEC   = 4'd4,
        S_T3    = 4'd5,
        S_T4    = 4'd6,
        S_T5    = 4'd7,
        S_T6    = 4'd8,
        S_T7    = 4'd9,
        S_DONE  = 4'd10,
        S_FAULT = 4'd15
    } state_t;

    typedef enum logic [1:0] {
        K_LD  = 2'd0,
        K_LDI = 2'd1,
        K_ST  = 2'd2
    } kind_t;

    state_t      state_q, state_d;
    kind_t       kind_q, kind_d;
    cnt_t        cnt_q, cnt_d;
    logic [1:0]  code_q, code_d;
    logic [17:0] ctrl_q, ctrl_d;
    logic [5:0]  opsel_q, opsel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;

    logic        wait_active;
    logic        wait_hs;
    state_t      wait_next;
    state_t      end_state;
    logic [4:0]  opcode;
    logic        ir_unused;

    assign opcode    = bus.ir[31:27];
    assign ir_unused = ^bus.ir[26:0];

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        code_d      = code_q;
        wait_active = 1'b0;
        wait_hs     = 1'b0;
        wait_next   = state_q;
        end_state   = (!CONTINUOUS || bus.halt_req) ? S_DONE : S_T0;

        case (state_q)
            S_IDLE, S_DONE: if (bus.run) state_d = S_T0;
            S_T0:  state_d = S_T1;
            S_T1: begin
                wait_active = 1'b1;
                wait_hs     = bus.memFinished;
                wait_next   = S_T2;
            end
            S_T2:  state_d = S_DEC;
            S_DEC: begin
                state_d = S_T3;
                if (opcode == OP_LD)       kind_d = K_LD;
                else if (opcode == OP_LDI) kind_d = K_LDI;
                else if (opcode == OP_ST)  kind_d = K_ST;
                else begin
                    state_d = S_FAULT;
                    code_d  = 2'b10;
                end
            end
            S_T3:  state_d = S_T4;
            S_T4: begin
                wait_active = 1'b1;
                wait_hs     = bus.finished;
                wait_next   = S_T5;
            end
            S_T5:  state_d = (kind_q == K_LDI) ? end_state : S_T6;
            S_T6: begin
                if (kind_q == K_LD) begin
                    wait_active = 1'b1;
                    wait_hs     = bus.memFinished;
                    wait_next   = S_T7;
                end else begin
                    state_d = S_T7;
                end
            end
            S_T7: begin
                if (kind_q == K_ST) begin
                    wait_active = 1'b1;
                    wait_hs     = bus.memFinished;
                    wait_next   = end_state;
                end else begin
                    state_d = end_state;
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase

        // A handshake landing on the last allowed cycle still wins over the timeout
        if (wait_active) begin
            if (wait_hs) begin
                state_d = wait_next;
            end else if (cnt_q == cnt_t'(TIMEOUT - 1)) begin
                state_d = S_FAULT;
                code_d  = 2'b01;
            end
        end

        cnt_d = (wait_active && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
    end

    // Outputs decoded from the upcoming state so they register alongside it
    always_comb begin
        ctrl_d  = '0;
        opsel_d = '0;
        case (state_d)
            S_T0: ctrl_d[B_INCPC] = 1'b1;
            S_T1: begin
                ctrl_d[B_PCOUT] = 1'b1;
                ctrl_d[B_MARIN] = 1'b1;
                ctrl_d[B_READ]  = 1'b1;
                ctrl_d[B_MDRIN] = 1'b1;
            end
            S_T2: begin
                ctrl_d[B_MDROUT] = 1'b1;
                ctrl_d[B_IRIN]   = 1'b1;
            end
            S_T3: begin
                ctrl_d[B_GRB]   = 1'b1;
                ctrl_d[B_BAOUT] = 1'b1;
                ctrl_d[B_ROUT]  = 1'b1;
                ctrl_d[B_RYIN]  = 1'b1;
            end
            S_T4: begin
                ctrl_d[B_IMMOUT] = 1'b1;
                ctrl_d[B_RZIN]   = 1'b1;
                ctrl_d[B_START]  = (state_q != S_T4);
                opsel_d          = ALU_ADD_OP;
            end
            S_T5: begin
                ctrl_d[B_RZLOOUT] = 1'b1;
                if (kind_d == K_LDI) begin
                    ctrl_d[B_GRA] = 1'b1;
                    ctrl_d[B_RIN] = 1'b1;
                end else begin
                    ctrl_d[B_MARIN] = 1'b1;
                end
            end
            S_T6: begin
                ctrl_d[B_MDRIN] = 1'b1;
                if (kind_d == K_LD) begin
                    ctrl_d[B_READ] = 1'b1;
                end else begin
                    ctrl_d[B_GRA]  = 1'b1;
                    ctrl_d[B_ROUT] = 1'b1;
                end
            end
            S_T7: begin
                if (kind_d == K_LD) begin
                    ctrl_d[B_MDROUT] = 1'b1;
                    ctrl_d[B_GRA]    = 1'b1;
                    ctrl_d[B_RIN]    = 1'b1;
                end else begin
                    ctrl_d[B_WRITE] = 1'b1;
                end
            end
            default: ctrl_d = '0;
        endcase
        busy_d  = !(state_d inside {S_IDLE, S_DONE, S_FAULT});
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
    end

    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            state_q <= S_IDLE;
            kind_q  <= K_LD;
            cnt_q   <= '0;
            code_q  <= 2'b00;
            ctrl_q  <= '0;
            opsel_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            ctrl_q  <= ctrl_d;
            opsel_q <= opsel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign bus.ctrl       = ctrl_q;
    assign bus.opSelect   = opsel_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mem_instr_sequencer.sv
// Scoreboard bench: stimulus queues the expected output-change events, monitors compare each change.
module tb_mem_instr_sequencer;

    localparam logic [3:0] IDLE = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, DEC = 4'd4,
                           T3 = 4'd5, T4 = 4'd6, T5 = 4'd7, T6 = 4'd8, T7 = 4'd9,
                           DN = 4'd10, FLT = 4'd15;
    localparam int S_RUN = 0, S_MEM = 1, S_FIN = 2, S_HALT = 3;

    typedef struct {
        logic [32:0] vec;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    mem_instr_sequencer_if bus0();
    mem_instr_sequencer_if bus1();

    mem_instr_sequencer #(.TIMEOUT(16), .CONTINUOUS(1'b0)) u_single (
        .Clock(clk), .clear(clear), .bus(bus0));
    mem_instr_sequencer #(.TIMEOUT(16), .CONTINUOUS(1'b1)) u_cont (
        .Clock(clk), .clear(clear), .bus(bus1));

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_event(input int w, input logic [32:0] obs, input int gap);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (w == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        else if (w == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        n_checks++;
        if (!have) begin
            $display("FAIL unexpected_event inst=%0d got st=%0d ctrl=%05h op=%02h bdf=%03b code=%02b gap=%0d, required none",
                     w, obs[32:29], obs[28:11], obs[10:5], obs[4:2], obs[1:0], gap);
        end else if (obs !== e.vec || (e.gap >= 0 && gap != e.gap)) begin
            $display("FAIL event inst=%0d got st=%0d ctrl=%05h op=%02h bdf=%03b code=%02b gap=%0d, required st=%0d ctrl=%05h op=%02h bdf=%03b code=%02b gap=%0d",
                     w, obs[32:29], obs[28:11], obs[10:5], obs[4:2], obs[1:0], gap,
                     e.vec[32:29], e.vec[28:11], e.vec[10:5], e.vec[4:2], e.vec[1:0], e.gap);
        end else begin
            n_pass++;
            $display("ok inst=%0d st=%0d ctrl=%05h op=%02h bdf=%03b code=%02b gap=%0d",
                     w, obs[32:29], obs[28:11], obs[10:5], obs[4:2], obs[1:0], gap);
        end
    endtask

    logic [32:0] prev0 = '0, prev1 = '0, cur0, cur1;
    int gap0 = 0, gap1 = 0;

    always @(negedge clk) begin
        cur0 = {bus0.state, bus0.ctrl, bus0.opSelect, bus0.busy, bus0.done, bus0.fault, bus0.fault_code};
        gap0 = gap0 + 1;
        if (cur0 !== prev0) begin
            check_event(0, cur0, gap0);
            gap0  = 0;
            prev0 = cur0;
        end
    end

    always @(negedge clk) begin
        cur1 = {bus1.state, bus1.ctrl, bus1.opSelect, bus1.busy, bus1.done, bus1.fault, bus1.fault_code};
        gap1 = gap1 + 1;
        if (cur1 !== prev1) begin
            check_event(1, cur1, gap1);
            gap1  = 0;
            prev1 = cur1;
        end
    end

    task automatic push(input int w, input logic [32:0] v, input int gap);
        exp_t e;
        e.vec = v;
        e.gap = gap;
        if (w == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // Busy-state event; only T4 carries the add opcode on opSelect
    task automatic pb(input int w, input logic [3:0] s, input logic [17:0] c, input int gap);
        push(w, {s, c, (s == T4) ? 6'h04 : 6'h00, 3'b100, 2'b00}, gap);
    endtask
    task automatic pdone(input int w, input int gap);
        push(w, {DN, 18'h0, 6'h00, 3'b010, 2'b00}, gap);
    endtask
    task automatic pfault(input int w, input logic [1:0] code, input int gap);
        push(w, {FLT, 18'h0, 6'h00, 3'b001, code}, gap);
    endtask
    task automatic pidle(input int w);
        push(w, 33'h0, -1);
    endtask

    task automatic drive(input int w, input int sig, input logic v);
        if (w == 0) begin
            case (sig)
                S_RUN:   bus0.run = v;
                S_MEM:   bus0.memFinished = v;
                S_FIN:   bus0.finished = v;
                default: bus0.halt_req = v;
            endcase
        end else begin
            case (sig)
                S_RUN:   bus1.run = v;
                S_MEM:   bus1.memFinished = v;
                S_FIN:   bus1.finished = v;
                default: bus1.halt_req = v;
            endcase
        end
    endtask

    task automatic wait_st(input int w, input logic [3:0] s);
        int n;
        n = 0;
        while (((w == 0) ? bus0.state : bus1.state) != s && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_checks++;
            $display("FAIL wait_state inst=%0d got st=%0d, required st=%0d within 100 cycles",
                     w, (w == 0) ? bus0.state : bus1.state, s);
        end
    endtask

    task automatic go(input int w);
        drive(w, S_RUN, 1'b1);
        wait_st(w, T0);
        drive(w, S_RUN, 1'b0);
    endtask

    // Wait for state s, let it last delay+1 cycles, then a one-cycle handshake ends it
    task automatic pulse(input int w, input int sig, input logic [3:0] s, input int delay);
        wait_st(w, s);
        repeat (delay) @(negedge clk);
        drive(w, sig, 1'b1);
        @(negedge clk);
        drive(w, sig, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 clear = 1'b0;
        @(negedge clk);
        #2 clear = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus0.run = 0; bus0.halt_req = 0; bus0.ir = '0; bus0.memFinished = 0; bus0.finished = 0;
        bus1.run = 0; bus1.halt_req = 0; bus1.ir = '0; bus1.memFinished = 0; bus1.finished = 0;
        repeat (3) @(negedge clk);
        n_checks += 2;
        if ({bus0.state, bus0.ctrl, bus0.opSelect, bus0.busy, bus0.done, bus0.fault, bus0.fault_code} !== 33'h0)
            $display("FAIL reset_single got st=%0d ctrl=%05h, required all zero", bus0.state, bus0.ctrl);
        else n_pass++;
        if ({bus1.state, bus1.ctrl, bus1.opSelect, bus1.busy, bus1.done, bus1.fault, bus1.fault_code} !== 33'h0)
            $display("FAIL reset_cont got st=%0d ctrl=%05h, required all zero", bus1.state, bus1.ctrl);
        else n_pass++;
        clear = 1'b1;
        repeat (2) @(negedge clk);

        // ldi r1,4(r2): fetch handshake after 3 T1 cycles, ALU after 2 T4 cycles
        bus0.ir = 32'h08900004;
        pb(0, T0, 18'h10000, -1); pb(0, T1, 18'h2D000, 1); pb(0, T2, 18'h00C00, 3);
        pb(0, DEC, 18'h0, 1);     pb(0, T3, 18'h001B0, 1); pb(0, T4, 18'h0000D, 1);
        pb(0, T4, 18'h0000C, 1);  pb(0, T5, 18'h00242, 1); pdone(0, 1);
        go(0);
        pulse(0, S_MEM, T1, 2);
        pulse(0, S_FIN, T4, 1);
        wait_st(0, DN);
        repeat (3) @(negedge clk);

        // ld: ALU handshake on the very last allowed T4 cycle must still advance
        bus0.ir = 32'h00A00008;
        pb(0, T0, 18'h10000, -1); pb(0, T1, 18'h2D000, 1); pb(0, T2, 18'h00C00, 2);
        pb(0, DEC, 18'h0, 1);     pb(0, T3, 18'h001B0, 1); pb(0, T4, 18'h0000D, 1);
        pb(0, T4, 18'h0000C, 1);  pb(0, T5, 18'h08002, 15); pb(0, T6, 18'h05000, 1);
        pb(0, T7, 18'h00A40, 2);  pdone(0, 1);
        go(0);
        pulse(0, S_MEM, T1, 1);
        pulse(0, S_FIN, T4, 15);
        pulse(0, S_MEM, T6, 1);
        wait_st(0, DN);
        repeat (3) @(negedge clk);

        // st: a stray memFinished in T6 must not shorten the T7 write wait
        bus0.ir = 32'h10000000;
        pb(0, T0, 18'h10000, -1); pb(0, T1, 18'h2D000, 1); pb(0, T2, 18'h00C00, 1);
        pb(0, DEC, 18'h0, 1);     pb(0, T3, 18'h001B0, 1); pb(0, T4, 18'h0000D, 1);
        pb(0, T5, 18'h08002, 1);  pb(0, T6, 18'h01280, 1); pb(0, T7, 18'h02000, 1);
        pdone(0, 4);
        go(0);
        pulse(0, S_MEM, T1, 0);
        pulse(0, S_FIN, T4, 0);
        pulse(0, S_MEM, T6, 0);
        pulse(0, S_MEM, T7, 3);
        wait_st(0, DN);
        repeat (3) @(negedge clk);

        // Illegal opcode: DEC goes straight to FAULT, run then ignored
        bus0.ir = 32'hF8000000;
        pb(0, T0, 18'h10000, -1); pb(0, T1, 18'h2D000, 1); pb(0, T2, 18'h00C00, 1);
        pb(0, DEC, 18'h0, 1);     pfault(0, 2'b10, 1);
        go(0);
        pulse(0, S_MEM, T1, 0);
        wait_st(0, FLT);
        drive(0, S_RUN, 1'b1);
        repeat (6) @(negedge clk);
        drive(0, S_RUN, 1'b0);
        pidle(0);
        do_reset();
        repeat (3) @(negedge clk);

        // Timeout: no memFinished, FAULT after 16 T1 cycles
        bus0.ir = 32'h08900004;
        pb(0, T0, 18'h10000, -1); pb(0, T1, 18'h2D000, 1); pfault(0, 2'b01, 16);
        go(0);
        wait_st(0, FLT);
        drive(0, S_RUN, 1'b1);
        repeat (5) @(negedge clk);
        drive(0, S_RUN, 1'b0);
        pidle(0);
        do_reset();
        repeat (3) @(negedge clk);

        // clear during T4: outputs drop before the next clock edge, no re-issued start
        pb(0, T0, 18'h10000, -1); pb(0, T1, 18'h2D000, 1); pb(0, T2, 18'h00C00, 1);
        pb(0, DEC, 18'h0, 1);     pb(0, T3, 18'h001B0, 1); pb(0, T4, 18'h0000D, 1);
        pb(0, T4, 18'h0000C, 1);  pidle(0);
        go(0);
        pulse(0, S_MEM, T1, 0);
        wait_st(0, T4);
        @(negedge clk);
        #2 clear = 1'b0;
        #1;
        n_checks++;
        if (bus0.ctrl !== 18'h0 || bus0.state !== IDLE || bus0.busy !== 1'b0 || bus0.opSelect !== 6'h0)
            $display("FAIL async_clear got st=%0d ctrl=%05h busy=%b op=%02h, required st=0 ctrl=00000 busy=0 op=00",
                     bus0.state, bus0.ctrl, bus0.busy, bus0.opSelect);
        else n_pass++;
        @(negedge clk);
        #2 clear = 1'b1;
        repeat (6) @(negedge clk);

        // Continuous mode: halt_req during the 2nd ldi ends it in DONE, no 3rd fetch
        bus1.ir = 32'h08900004;
        pb(1, T0, 18'h10000, -1); pb(1, T1, 18'h2D000, 1); pb(1, T2, 18'h00C00, 1);
        pb(1, DEC, 18'h0, 1);     pb(1, T3, 18'h001B0, 1); pb(1, T4, 18'h0000D, 1);
        pb(1, T5, 18'h00242, 1);
        pb(1, T0, 18'h10000, 1);  pb(1, T1, 18'h2D000, 1); pb(1, T2, 18'h00C00, 1);
        pb(1, DEC, 18'h0, 1);     pb(1, T3, 18'h001B0, 1); pb(1, T4, 18'h0000D, 1);
        pb(1, T5, 18'h00242, 1);  pdone(1, 1);
        go(1);
        pulse(1, S_MEM, T1, 0);
        pulse(1, S_FIN, T4, 0);
        pulse(1, S_MEM, T1, 0);
        drive(1, S_HALT, 1'b1);
        pulse(1, S_FIN, T4, 0);
        wait_st(1, DN);
        drive(1, S_HALT, 1'b0);
        repeat (10) @(negedge clk);

        for (int i = 0; i < 50 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
        while (q0.size() > 0) begin
            exp_t e;
            e = q0.pop_front();
            n_checks++;
            $display("FAIL missing_event inst=0 got none, required st=%0d ctrl=%05h", e.vec[32:29], e.vec[28:11]);
        end
        while (q1.size() > 0) begin
            exp_t e;
            e = q1.pop_front();
            n_checks++;
            $display("FAIL missing_event inst=1 got none, required st=%0d ctrl=%05h", e.vec[32:29], e.vec[28:11]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
